// File: rtl/zfetch_if.sv
// Bus bundle for the depth-fetch stage: fragment input, z-test output and
// the Avalon-MM read master. The slave modport is the zfetch view; the
// master modport is the surrounding environment (rasterizer, z-test, memory).
interface zfetch_if;
  logic        frag_valid;
  logic [25:0] frag_addr;
  logic [23:0] frag_color;
  logic [31:0] frag_depth;
  logic        frag_done;
  logic        stall_out;
  logic        stall_in;
  logic        out_valid;
  logic [25:0] addr_out;
  logic [31:0] color_out;
  logic [31:0] old_depth_out;
  logic [31:0] new_depth_out;
  logic        done_out;
  logic [25:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;

  modport slave (
    input  frag_valid, frag_addr, frag_color, frag_depth, frag_done, stall_in,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output stall_out, out_valid, addr_out, color_out, old_depth_out,
    output new_depth_out, done_out,
    output master_address, master_read, master_write, master_byteenable,
    output master_writedata
  );

  modport master (
    output frag_valid, frag_addr, frag_color, frag_depth, frag_done, stall_in,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  stall_out, out_valid, addr_out, color_out, old_depth_out,
    input  new_depth_out, done_out,
    input  master_address, master_read, master_write, master_byteenable,
    input  master_writedata
  );
endinterface

// File: rtl/zfetch.sv
// Depth-fetch stage ahead of the z-test. Each accepted fragment is parked in
// a small pending FIFO while its stored depth word is read over Avalon-MM;
// read responses come back in issue order and pop the FIFO head, so the
// fragment and its old depth are forwarded together one cycle later.
module zfetch #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int DEPTH_OFFSET    = 4
) (
  input logic      clock,
  input logic      reset,
  zfetch_if.slave  bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [25:0] fifo_addr  [MAX_OUTSTANDING];
  logic [23:0] fifo_color [MAX_OUTSTANDING];
  logic [31:0] fifo_depth [MAX_OUTSTANDING];
  logic        fifo_done  [MAX_OUTSTANDING];

  logic        rd_p0;
  logic [25:0] addr_p0;

  logic        vld_p1;
  logic [25:0] addr_p1;
  logic [23:0] color_p1;
  logic [31:0] old_p1;
  logic [31:0] new_p1;
  logic        done_p1;

  logic stall;
  logic accept;
  logic pop;

  // A read in progress or a full FIFO holds off the rasterizer, as does a
  // half-full z-test FIFO; reads already in flight are covered by its slack.
  assign stall  = (state == S_READ) | (count == FULL) | bus.stall_in;
  assign accept = bus.frag_valid & ~stall;
  // A response with nothing pending is a leftover from before a reset.
  assign pop    = bus.master_readdatavalid & (count != '0);

  // Stage p0: issue one Avalon read per accepted fragment, held under waitrequest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rd_p0   <= 1'b0;
      addr_p0 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_p0 <= bus.frag_addr + 26'(DEPTH_OFFSET);
            rd_p0   <= 1'b1;
            state   <= S_READ;
          end
        end
        S_READ: begin
          if (!bus.master_waitrequest) begin
            rd_p0 <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pending FIFO pointers and occupancy; a same-cycle push and pop cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Pending FIFO storage: fragment attributes waiting for their depth word.
  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_addr[wr_ptr]  <= bus.frag_addr;
      fifo_color[wr_ptr] <= bus.frag_color;
      fifo_depth[wr_ptr] <= bus.frag_depth;
      fifo_done[wr_ptr]  <= bus.frag_done;
    end
  end

  // Stage p1: pair the returning depth with the FIFO head; data holds between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      color_p1 <= '0;
      old_p1   <= '0;
      new_p1   <= '0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        addr_p1  <= fifo_addr[rd_ptr];
        color_p1 <= fifo_color[rd_ptr];
        old_p1   <= bus.master_readdata;
        new_p1   <= fifo_depth[rd_ptr];
        done_p1  <= fifo_done[rd_ptr];
      end
    end
  end

  assign bus.stall_out         = stall;
  assign bus.master_address    = addr_p0;
  assign bus.master_read       = rd_p0;
  assign bus.master_write      = 1'b0;
  assign bus.master_byteenable = 4'b1111;
  assign bus.master_writedata  = 32'h0;

  assign bus.out_valid     = vld_p1;
  assign bus.addr_out      = addr_p1;
  assign bus.color_out     = {8'h00, color_p1};
  assign bus.old_depth_out = old_p1;
  assign bus.new_depth_out = new_p1;
  assign bus.done_out      = done_p1;

endmodule

// File: tb/tb_zfetch.sv
// Bench for zfetch: directed scenarios plus a randomized stream, with an
// Avalon memory responder and a transaction-level reference model.
module tb_zfetch;
  localparam int MAXO = 4;
  localparam int OFFS = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  zfetch_if bus();

  zfetch #(.MAX_OUTSTANDING(MAXO), .DEPTH_OFFSET(OFFS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [25:0] a;
    logic [23:0] c;
    logic [31:0] d;
    logic        dn;
  } frag_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  frag_t fq[$];     // fragments accepted, not yet forwarded
  rsp_t  rq[$];     // reads issued on the bus, not yet answered

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model state
  bit          m_busy     = 0;
  int          inflight   = 0;
  logic [25:0] m_addr     = '0;
  logic        m_rd       = 1'b0;
  logic        e_vld      = 1'b0;
  frag_t       e_frag     = '0;
  logic [31:0] e_old      = '0;
  bit          last_accept = 0;

  // responder controls
  int lat         = 3;
  bit auto_rsp    = 1;
  bit release_now = 0;
  bit stray_now   = 0;

  function automatic logic [31:0] mem_val(logic [25:0] a);
    if (a == 26'h104) return 32'h20;
    return (32'(a) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid",     32'(bus.out_valid),     32'(e_vld));
    check("addr_out",      32'(bus.addr_out),      32'(e_frag.a));
    check("color_out",     bus.color_out,          {8'h00, e_frag.c});
    check("old_depth_out", bus.old_depth_out,      e_old);
    check("new_depth_out", bus.new_depth_out,      e_frag.d);
    check("done_out",      32'(bus.done_out),      32'(e_frag.dn));
    check("master_read",   32'(bus.master_read),   32'(m_rd));
    check("master_address",32'(bus.master_address),32'(m_addr));
    check("master_write",  32'(bus.master_write),  32'h0);
    check("byteenable",    32'(bus.master_byteenable), 32'hF);
    check("writedata",     bus.master_writedata,   32'h0);
  endtask

  task automatic set_frag(logic fv, logic [25:0] a, logic [23:0] c, logic [31:0] d, logic dn);
    bus.frag_valid = fv;
    bus.frag_addr  = a;
    bus.frag_color = c;
    bus.frag_depth = d;
    bus.frag_done  = dn;
  endtask

  task automatic rand_frag(logic fv);
    set_frag(fv, 26'($urandom), 24'($urandom), $urandom, 1'($urandom));
  endtask

  // One clock cycle: present memory response, check stall, advance the
  // model across the edge, then check the registered outputs.
  task automatic step();
    logic  rdv;
    logic  stall_exp;
    logic  accept;
    logic  pop;
    frag_t f;
    frag_t h;
    rsp_t  r;
    rdv = 1'b0;
    bus.master_readdata = $urandom;
    if (stray_now) begin
      rdv = 1'b1;
    end else if (rq.size() > 0 && (auto_rsp ? (rq[0].due <= cyc) : release_now)) begin
      r = rq.pop_front();
      rdv = 1'b1;
      bus.master_readdata = r.data;
    end
    bus.master_readdatavalid = rdv;
    #1;
    stall_exp = m_busy || (inflight == MAXO) || bus.stall_in;
    check("stall_out", 32'(bus.stall_out), 32'(stall_exp));
    if (bus.master_read && !bus.master_waitrequest) begin
      r.due  = cyc + lat;
      r.data = mem_val(bus.master_address);
      rq.push_back(r);
    end
    f = '{bus.frag_addr, bus.frag_color, bus.frag_depth, bus.frag_done};
    accept = bus.frag_valid && !stall_exp;
    pop    = rdv && (inflight > 0);
    if (m_busy && !bus.master_waitrequest) begin
      m_busy = 0;
      m_rd   = 1'b0;
    end
    if (pop) begin
      h      = fq.pop_front();
      e_frag = h;
      e_old  = mem_val(h.a + 26'(OFFS));
      inflight--;
    end
    e_vld = pop;
    if (accept) begin
      fq.push_back(f);
      m_addr = f.a + 26'(OFFS);
      m_rd   = 1'b1;
      m_busy = 1;
      inflight++;
    end
    last_accept = accept;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.frag_valid = 1'b0;
    bus.stall_in = 1'b0;
    bus.master_waitrequest = 1'b0;
    auto_rsp = 1;
    while ((inflight > 0 || rq.size() > 0) && n < 200) begin
      step();
      n++;
    end
    step();
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", inflight);
    end
  endtask

  task automatic do_reset();
    bus.frag_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    m_busy = 0; inflight = 0; m_addr = '0; m_rd = 1'b0;
    e_vld = 1'b0; e_frag = '0; e_old = '0;
    fq.delete();
    rq.delete();
    check_outputs();
    check("stall_out_rst", 32'(bus.stall_out), 32'(bus.stall_in));
    @(negedge clock);
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    int k;
    int guard;
    set_frag(1'b0, '0, '0, '0, 1'b0);
    bus.stall_in = 1'b0;
    bus.master_readdata = '0;
    bus.master_readdatavalid = 1'b0;
    bus.master_waitrequest = 1'b0;

    // reset state
    @(negedge clock);
    @(negedge clock);
    check_outputs();
    check("stall_out_rst", 32'(bus.stall_out), 32'h0);
    reset = 1'b1;

    // single fragment, response three cycles after the read
    lat = 3;
    set_frag(1'b1, 26'h100, 24'hFF0000, 32'h10, 1'b1);
    step();
    set_frag(1'b0, '0, '0, '0, 1'b1);
    repeat (6) step();
    check("t1_old_depth", bus.old_depth_out, 32'h20);
    check("t1_color", bus.color_out, 32'h00FF_0000);

    // waitrequest held high for five cycles
    set_frag(1'b1, 26'h100, 24'h00FF00, 32'h33, 1'b0);
    step();
    bus.master_waitrequest = 1'b1;
    rand_frag(1'b1);
    repeat (5) step();
    bus.master_waitrequest = 1'b0;
    bus.frag_valid = 1'b0;
    step();
    drain();

    // eight back-to-back fragments against a slow memory
    lat = 10;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      set_frag(1'b1, 26'(32'h2000 + k * 16), 24'(k * 32'h010203), 32'(k + 100), 1'(k == 7));
      step();
      if (last_accept) k++;
      guard++;
    end
    drain();

    // push and pop in the same cycle at two outstanding
    auto_rsp = 0;
    release_now = 0;
    for (int i = 0; i < 2; i++) begin
      rand_frag(1'b1);
      step();
      bus.frag_valid = 1'b0;
      step();
    end
    rand_frag(1'b1);
    release_now = 1;
    step();
    release_now = 0;
    bus.frag_valid = 1'b0;
    step();
    drain();

    // stall_in with two reads in flight
    lat = 6;
    for (int i = 0; i < 2; i++) begin
      rand_frag(1'b1);
      step();
      bus.frag_valid = 1'b0;
      step();
    end
    bus.stall_in = 1'b1;
    rand_frag(1'b1);
    repeat (10) step();
    bus.stall_in = 1'b0;
    step();
    drain();

    // reset with three reads in flight, stray responses, address wrap
    lat = 20;
    k = 0;
    guard = 0;
    while (k < 3 && guard < 50) begin
      rand_frag(1'b1);
      step();
      if (last_accept) k++;
      guard++;
    end
    bus.frag_valid = 1'b0;
    step();
    do_reset();
    stray_now = 1;
    repeat (3) step();
    stray_now = 0;
    lat = 2;
    set_frag(1'b1, 26'h3FF_FFFC, 24'h123456, 32'hCAFE, 1'b1);
    step();
    check("wrap_address", 32'(bus.master_address), 32'h0);
    bus.frag_valid = 1'b0;
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_frag(1'($urandom_range(0, 1)));
      bus.stall_in = ($urandom_range(0, 5) == 0);
      bus.master_waitrequest = ($urandom_range(0, 2) == 0);
      lat = $urandom_range(1, 8);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zfetch.md
Name: zfetch

Overview:
- Depth-fetch stage directly upstream of the z-test stage.
- Accepts rasterized fragments: framebuffer address, colour, new depth, done flag.
- Reads the stored depth word for each fragment over an Avalon-MM read master.
- Forwards each fragment in order, with the fetched old depth, to the z-test input port.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads issued but not yet returned (power of 2, 2..16).
- DEPTH_OFFSET, 4, byte offset of the depth word from the fragment's colour address.

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- frag_valid  input  1  fragment present on frag_* inputs.
- frag_addr  input  26  colour address of the fragment.
- frag_color  input  24  RGB colour.
- frag_depth  input  32  new (interpolated) depth.
- frag_done  input  1  marks the last fragment of a primitive.
- stall_out  output  1  upstream must hold its fragment while high.
- stall_in  input  1  z-test FIFO half-full.
- out_valid  output  1  one-cycle pulse per forwarded fragment.
- addr_out  output  26  fragment colour address.
- color_out  output  32  {8'h00, colour}.
- old_depth_out  output  32  depth read from memory.
- new_depth_out  output  32  fragment depth.
- done_out  output  1  frag_done of the forwarded fragment.
- master_address  output  26  Avalon read address.
- master_read  output  1  Avalon read strobe.
- master_write  output  1  tied 0.
- master_byteenable  output  4  tied 4'b1111.
- master_writedata  output  32  tied 0.
- master_readdata  input  32  read data.
- master_readdatavalid  input  1  read data valid.
- master_waitrequest  input  1  Avalon wait.

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE; pending FIFO empty; outstanding count=0.
  - All outputs 0 at reset: out_valid, master_read, master_address, addr_out, color_out, old_depth_out, new_depth_out, done_out.
- Pending FIFO: MAX_OUTSTANDING entries of {addr, color, depth, done}.
  - count = entries pushed and not popped.
- stall_out = (state==S_READ) | (count==MAX_OUTSTANDING) | stall_in. It is combinational.
- Accept: frag_valid & !stall_out in S_IDLE. On accept:
  - Push the fragment into the pending FIFO.
  - master_address <= frag_addr + DEPTH_OFFSET, 26-bit, wraps modulo 2^26.
  - master_read <= 1; state <= S_READ.
- S_READ: hold master_read and master_address stable while master_waitrequest=1.
  - On the first cycle with waitrequest=0, the read is issued: master_read <= 0 and state <= S_IDLE.
  - Minimum spacing is therefore 2 cycles per fragment.
- Response: master_readdatavalid=1 pops the FIFO head. Next cycle:
  - out_valid=1; addr_out/color_out/new_depth_out/done_out come from the head entry.
  - old_depth_out = master_readdata.
  - Latency: 1 cycle from readdatavalid to out_valid.
- Data outputs hold their values after out_valid drops. out_valid is never held more than 1 cycle; there is no backpressure at the output.
  - stall_in only blocks new acceptances. The z-test half-full slack absorbs reads already in flight, so MAX_OUTSTANDING must not exceed half the z-test FIFO depth.
- Ordering: responses return in issue order, and fragments are forwarded strictly FIFO.
- Simultaneous push (accept) and pop (readdatavalid) in one cycle: count is unchanged and both operations complete.
- readdatavalid with count==0 (stray response, e.g. after reset mid-transfer): ignored; no out_valid; count stays 0.
- Reset asserted mid-read: read dropped immediately; pending fragments discarded; responses arriving later are treated as stray.
- frag_done has no effect without frag_valid.
- The count never exceeds MAX_OUTSTANDING and never underflows.

Test Plan:
- Single fragment, addr=0x100, color=0xFF0000, depth=0x10, done=1; waitrequest=0; readdata=0x20 three cycles after the read.
  - Expect master_address=0x104, one read cycle.
  - Expect out_valid 1 cycle after readdatavalid with addr_out=0x100, color_out=0x00FF0000, old=0x20, new=0x10, done_out=1.
- waitrequest held high for 5 cycles: master_read and master_address=0x104 held stable for all 5 cycles; stall_out high throughout; read issued once.
- Back-to-back stream, 8 fragments, responses delayed 10 cycles, MAX_OUTSTANDING=4:
  - stall_out rises after the 4th accept.
  - All 8 forwarded in order with correct depth pairing; count peaks at 4.
- Push and pop in the same cycle (accept while readdatavalid=1 at count=2): count stays 2; output and next address both correct.
- stall_in=1 with 2 reads in flight: no new accept; both in-flight fragments still emitted; accept resumes the cycle after stall_in=0.
- Reset pulsed with 3 reads in flight, then 3 stray readdatavalid pulses: no out_valid, count=0.
  - Next fragment at addr=0x3FFFFFC yields master_address=0x0000000 (wrap).
